// File: rtl/vscpu_pkg.sv
// ============================================================================
// Module : vscpu_pkg
// Brief  : Shared types and instruction-field helpers for the handshake CPU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vscpu_pkg;

    // Widest instruction word the field helpers can operate on.
    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NAND = 3'd1,
        OP_SRL  = 3'd2,
        OP_LT   = 3'd3,
        OP_CP   = 3'd4,
        OP_CPI  = 3'd5,
        OP_BZJ  = 3'd6,
        OP_MUL  = 3'd7
    } op_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_WAIT_I = 4'd1,
        S_DEC    = 4'd2,
        S_RD_A   = 4'd3,
        S_W_A    = 4'd4,
        S_RD_B   = 4'd5,
        S_W_B    = 4'd6,
        S_RD_I   = 4'd7,
        S_W_I    = 4'd8,
        S_EXEC   = 4'd9,
        S_WB     = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    function automatic op_t get_op(input logic [MAX_W-1:0] iw, input int dw);
        return op_t'(3'(iw >> (dw - 3)));
    endfunction

    function automatic logic get_imm(input logic [MAX_W-1:0] iw, input int dw);
        return 1'(iw >> (dw - 4));
    endfunction

    function automatic logic [MAX_W-1:0] get_field(input logic [MAX_W-1:0] iw,
                                                   input int lsb, input int aw);
        return (iw >> lsb) & ~({MAX_W{1'b1}} << aw);
    endfunction

    function automatic logic [MAX_W-1:0] get_a(input logic [MAX_W-1:0] iw, input int aw);
        return get_field(iw, aw, aw);
    endfunction

    function automatic logic [MAX_W-1:0] get_b(input logic [MAX_W-1:0] iw, input int aw);
        return get_field(iw, 0, aw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vscpu_alu.sv
// ============================================================================
// Module : vscpu_alu
// Brief  : Combinational ALU for ADD/NAND/SRL/LT/MUL; other opcodes pass b.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vscpu_alu
    import vscpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  op_t           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result
);

    localparam logic [DW-1:0] DW_V = DW'(DW);

    always_comb begin
        result = b;
        case (op)
            OP_ADD:  result = a + b;
            OP_NAND: result = ~(a & b);
            // Shift counts at or beyond DW turn the operation into a left shift.
            OP_SRL:  result = (b < DW_V) ? (a >> b) : (a << (b - DW_V));
            OP_LT:   result = (a < b) ? DW'(1) : '0;
            OP_MUL:  result = a * b;
            default: result = b;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/vscpu_mem_hs.sv
// ============================================================================
// Module : vscpu_mem_hs
// Brief  : Multi-cycle mem-to-mem CPU with req/gnt/rvalid memory handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vscpu_mem_hs
    import vscpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 14,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          halted,
    output logic [CW-1:0] retired
);

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [DW-1:0] iw, iw_n;
    logic [DW-1:0] r1, r1_n;
    logic [DW-1:0] r2, r2_n;
    logic [DW-1:0] res, res_n;
    logic [CW-1:0] retired_n;
    logic          req_n, we_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n;

    logic [MAX_W-1:0] iw_ext;
    op_t              op;
    logic             imm;
    logic [AW-1:0]    fa, fb;
    logic [DW-1:0]    imm_ext;
    logic [DW-1:0]    alu_b, alu_out;
    logic             accept;
    logic             br_taken;
    logic [AW-1:0]    br_target;

    assign iw_ext  = MAX_W'(iw);
    assign op      = get_op(iw_ext, DW);
    assign imm     = get_imm(iw_ext, DW);
    assign fa      = AW'(get_a(iw_ext, AW));
    assign fb      = AW'(get_b(iw_ext, AW));
    assign imm_ext = DW'(fb);
    assign alu_b   = imm ? imm_ext : r2;
    assign accept  = mem_req & mem_gnt;

    // Non-immediate BZJ reads *B into r1 first, then *A into r2.
    assign br_taken  = imm | (r1 == '0);
    assign br_target = imm ? AW'(r1 + imm_ext) : r2[AW-1:0];

    vscpu_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (r1),
        .b      (alu_b),
        .result (alu_out)
    );

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        iw_n      = iw;
        r1_n      = r1;
        r2_n      = r2;
        res_n     = res;
        retired_n = retired;

        case (state)
            S_FETCH:  if (accept) state_n = S_WAIT_I;
            S_WAIT_I: begin
                if (mem_rvalid) begin
                    iw_n    = mem_rdata;
                    state_n = S_DEC;
                end
            end
            S_DEC: begin
                if (op == OP_CP && imm) begin
                    res_n   = imm_ext;
                    state_n = S_WB;
                end else if ((op == OP_CP || op == OP_CPI) && !imm) begin
                    state_n = S_RD_B;
                end else begin
                    state_n = S_RD_A;
                end
            end
            S_RD_A:   if (accept) state_n = S_W_A;
            S_W_A: begin
                if (mem_rvalid) begin
                    r1_n    = mem_rdata;
                    state_n = (imm && op != OP_CPI) ? S_EXEC : S_RD_B;
                end
            end
            S_RD_B:   if (accept) state_n = S_W_B;
            S_W_B: begin
                if (mem_rvalid) begin
                    r2_n    = mem_rdata;
                    state_n = (op == OP_CPI) ? S_RD_I : S_EXEC;
                end
            end
            S_RD_I: begin
                if (imm) begin
                    res_n   = r2;
                    state_n = S_WB;
                end else if (accept) begin
                    state_n = S_W_I;
                end
            end
            S_W_I: begin
                if (mem_rvalid) begin
                    res_n   = mem_rdata;
                    state_n = S_WB;
                end
            end
            S_EXEC: begin
                if (op == OP_BZJ) begin
                    retired_n = retired + CW'(1);
                    pc_n      = br_taken ? br_target : pc + AW'(1);
                    state_n   = (br_taken && br_target == pc) ? S_HALT : S_FETCH;
                end else begin
                    res_n   = alu_out;
                    state_n = S_WB;
                end
            end
            S_WB: begin
                if (accept) begin
                    retired_n = retired + CW'(1);
                    pc_n      = pc + AW'(1);
                    state_n   = S_FETCH;
                end
            end
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_FETCH;
        endcase

        // Bus outputs are derived from the state being entered so they are registered.
        req_n   = 1'b0;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        case (state_n)
            S_FETCH: begin
                req_n  = 1'b1;
                addr_n = pc_n;
            end
            S_RD_A: begin
                req_n  = 1'b1;
                addr_n = (op == OP_BZJ && !imm) ? fb : fa;
            end
            S_RD_B: begin
                req_n  = 1'b1;
                addr_n = (op == OP_BZJ && !imm) ? fa : fb;
            end
            S_RD_I: begin
                req_n  = !imm;
                addr_n = r2_n[AW-1:0];
            end
            S_WB: begin
                req_n   = 1'b1;
                we_n    = 1'b1;
                addr_n  = (op == OP_CPI && imm) ? r1[AW-1:0] : fa;
                wdata_n = res_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            iw        <= '0;
            r1        <= '0;
            r2        <= '0;
            res       <= '0;
            retired   <= '0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            iw        <= iw_n;
            r1        <= r1_n;
            r2        <= r2_n;
            res       <= res_n;
            retired   <= retired_n;
            halted    <= (state_n == S_HALT);
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vscpu_mem_hs.sv
// ============================================================================
// Module : tb_vscpu_mem_hs
// Brief  : Directed programs against a handshake memory model with scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vscpu_mem_hs;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int CW = 32;

    localparam logic [2:0] L_ADD = 3'd0, L_NAND = 3'd1, L_SRL = 3'd2, L_LT = 3'd3;
    localparam logic [2:0] L_CP = 3'd4, L_CPI = 3'd5, L_BZJ = 3'd6, L_MUL = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid, halted;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] retired;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]    mem [1<<AW];
    logic [AW+DW-1:0] exp_wr[$];
    logic [AW-1:0]    rd_log[$];
    bit               rand_mode = 1'b0;
    bit               gnt_block = 1'b0;
    int               fixed_lat = 1;
    int               rd_cnt    = 0;
    logic [AW-1:0]    rd_addr   = '0;

    vscpu_mem_hs #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] op, input logic imm,
                                        input int a, input int b);
        return {op, imm, 14'(a), 14'(b)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: grant and read-latency decisions are made on the falling edge.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[rd_addr];
                end
            end
            mem_gnt = !gnt_block && (rd_cnt == 0) && (!rand_mode || $urandom_range(0, 2) != 0);
            if (mem_req && mem_gnt && !rst) begin
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                end else begin
                    rd_addr = mem_addr;
                    rd_cnt  = rand_mode ? int'($urandom_range(1, 5)) : fixed_lat;
                    rd_log.push_back(mem_addr);
                end
            end
        end
    end

    // Monitor: scoreboards every accepted write and checks request stability.
    initial begin
        bit               pend;
        logic [AW+DW+1:0] held;
        logic [AW+DW-1:0] e;
        pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (pend && !rst)
                check("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, held[AW+DW:0]});
            pend = mem_req && !mem_gnt && !rst;
            held = {mem_req, mem_we, mem_addr, mem_wdata};
            if (mem_req && mem_gnt && mem_we && !rst) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_addr, mem_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    check("write", {mem_addr, mem_wdata}, e);
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rd_cnt = 0;
        rd_log.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_halted", halted, 0);
        check("rst_retired", retired, 0);
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halted"}, halted, 1);
        repeat (3) @(negedge clk);
        check({name, "_halt_noreq"}, mem_req, 0);
        check({name, "_sb_empty"}, exp_wr.size(), 0);
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[10] = 32'd5;
        mem[11] = 32'd7;
        mem[0]  = enc(L_ADD, 1'b0, 10, 11);
        mem[1]  = enc(L_BZJ, 1'b1, 12, 1);
    endtask

    initial begin
        int n;

        // Program 1: ADD then self-jump halt, single-cycle latency.
        load_prog1();
        do_reset();
        exp_wr.push_back({14'd10, 32'd12});
        run_to_halt("p1", 500);
        check("p1_mem10", mem[10], 12);
        check("p1_retired", retired, 2);
        check("p1_nreads", rd_log.size(), 5);
        check("p1_last_fetch", rd_log[3], 1);

        // Shift right immediate, both the wrap-to-left and plain right forms.
        clear_mem();
        mem[20] = 32'h8000_0001;
        mem[21] = 32'h8000_0001;
        mem[0]  = enc(L_SRL, 1'b1, 20, 33);
        mem[1]  = enc(L_SRL, 1'b1, 21, 1);
        mem[2]  = enc(L_BZJ, 1'b1, 12, 2);
        do_reset();
        exp_wr.push_back({14'd20, 32'h0000_0002});
        exp_wr.push_back({14'd21, 32'h4000_0000});
        run_to_halt("srl", 500);
        check("srl_retired", retired, 3);

        // Indirect copies.
        clear_mem();
        mem[31] = 32'd40;
        mem[40] = 32'hDEAD;
        mem[32] = 32'd50;
        mem[33] = 32'd9;
        mem[0]  = enc(L_CPI, 1'b0, 30, 31);
        mem[1]  = enc(L_CPI, 1'b1, 32, 33);
        mem[2]  = enc(L_BZJ, 1'b1, 12, 2);
        do_reset();
        exp_wr.push_back({14'd30, 32'hDEAD});
        exp_wr.push_back({14'd50, 32'd9});
        run_to_halt("cpi", 500);
        check("cpi_mem30", mem[30], 32'hDEAD);
        check("cpi_mem50", mem[50], 9);
        check("cpi_retired", retired, 3);

        // Remaining ALU and copy forms.
        clear_mem();
        mem[34] = 32'hF0F0_F0F0;  mem[35] = 32'hFF00_FF00;
        mem[36] = 32'd4;
        mem[37] = 32'd9;          mem[38] = 32'd9;
        mem[39] = 32'h0001_0001;  mem[41] = 32'h0003_0003;
        mem[43] = 32'h1234_5678;
        mem[45] = 32'hFFFF_FFFF;  mem[46] = 32'hFFFF_FFFF;
        mem[47] = 32'd7;
        mem[48] = 32'h8000_0000;  mem[49] = 32'd4;
        mem[0]  = enc(L_NAND, 1'b0, 34, 35);
        mem[1]  = enc(L_LT,   1'b1, 36, 5);
        mem[2]  = enc(L_LT,   1'b0, 37, 38);
        mem[3]  = enc(L_MUL,  1'b0, 39, 41);
        mem[4]  = enc(L_CP,   1'b0, 42, 43);
        mem[5]  = enc(L_CP,   1'b1, 44, 14'h2ABC);
        mem[6]  = enc(L_ADD,  1'b1, 45, 14'h100);
        mem[7]  = enc(L_NAND, 1'b1, 46, 14'h0F);
        mem[8]  = enc(L_MUL,  1'b1, 47, 3);
        mem[9]  = enc(L_SRL,  1'b0, 48, 49);
        mem[10] = enc(L_BZJ,  1'b1, 12, 10);
        do_reset();
        exp_wr.push_back({14'd34, 32'h0FFF_0FFF});
        exp_wr.push_back({14'd36, 32'd1});
        exp_wr.push_back({14'd37, 32'd0});
        exp_wr.push_back({14'd39, 32'h0006_0003});
        exp_wr.push_back({14'd42, 32'h1234_5678});
        exp_wr.push_back({14'd44, 32'h0000_2ABC});
        exp_wr.push_back({14'd45, 32'h0000_00FF});
        exp_wr.push_back({14'd46, 32'hFFFF_FFF0});
        exp_wr.push_back({14'd47, 32'd21});
        exp_wr.push_back({14'd48, 32'h0800_0000});
        run_to_halt("alu", 1000);
        check("alu_retired", retired, 11);

        // BZJ taken: fetch continues at *A.
        clear_mem();
        mem[60]  = 32'd100;
        mem[61]  = 32'd0;
        mem[0]   = enc(L_BZJ, 1'b0, 60, 61);
        mem[100] = enc(L_BZJ, 1'b1, 62, 100);
        do_reset();
        run_to_halt("bzj_t", 500);
        check("bzj_t_fetch", rd_log[3], 100);
        check("bzj_t_retired", retired, 2);

        // BZJ not taken: fetch continues at PC+1.
        clear_mem();
        mem[60] = 32'd100;
        mem[61] = 32'd3;
        mem[0]  = enc(L_BZJ, 1'b0, 60, 61);
        mem[1]  = enc(L_BZJ, 1'b1, 62, 1);
        do_reset();
        run_to_halt("bzj_n", 500);
        check("bzj_n_fetch", rd_log[3], 1);
        check("bzj_n_retired", retired, 2);

        // Program 1 under random latency and grant stalls.
        load_prog1();
        rand_mode = 1'b1;
        do_reset();
        exp_wr.push_back({14'd10, 32'd12});
        run_to_halt("rnd", 2000);
        check("rnd_mem10", mem[10], 12);
        check("rnd_retired", retired, 2);
        check("rnd_last_fetch", rd_log[3], 1);
        rand_mode = 1'b0;

        // Reset while *B of the ADD is outstanding; its rvalid arrives after reset.
        load_prog1();
        fixed_lat = 4;
        do_reset();
        n = 0;
        while (rd_log.size() < 3 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("mid_reached_wb", rd_log.size(), 3);
        @(negedge clk);
        rst = 1'b1;
        gnt_block = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_retired", retired, 0);
        check("mid_no_write", mem[10], 5);
        @(negedge clk);
        #2;
        check("mid_first_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 14'd0});
        repeat (3) @(negedge clk);
        check("mid_still_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 14'd0});
        exp_wr.push_back({14'd10, 32'd12});
        gnt_block = 1'b0;
        run_to_halt("mid", 1000);
        check("mid_post_fetch0", rd_log[3], 0);
        check("mid_mem10", mem[10], 12);
        check("mid_retired", retired, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
